// File: rtl/wash_ctrl.sv
// Washing-machine cycle controller: decodes key-code changes into commands and sequences
// FILL/WASH/DRAIN/SPIN/DONE on a 1 s tick. Optional macro WASH_DIR_ALT_EN alternates drum direction in WASH.
module wash_ctrl #(
   parameter int unsigned TICK_DIV = 20_000_000,
   parameter int unsigned FILL_S   = 60,
   parameter int unsigned WASH_S   = 300,
   parameter int unsigned DRAIN_S  = 60,
   parameter int unsigned SPIN_S   = 120,
   parameter int unsigned DONE_S   = 5,
   parameter int unsigned DIR_S    = 10
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [2:0] key_value,
   output logic       valve_in,
   output logic       valve_out,
   output logic       motor_fwd,
   output logic       motor_rev,
   output logic       spin,
   output logic       buzzer,
   output logic       paused,
   output logic [2:0] state,
   output logic [9:0] remain_s
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned RW = 10;

   if (TICK_DIV < 2 || TICK_DIV > 2**25 || FILL_S == 0 || FILL_S > 1023 || WASH_S == 0 ||
       WASH_S > 1023 || DRAIN_S == 0 || DRAIN_S > 1023 || SPIN_S == 0 || SPIN_S > 1023 ||
       DONE_S == 0 || DONE_S > 1023 || DIR_S == 0 || DIR_S > 1023) begin : g_param_chk
      $error("wash_ctrl: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_FILL  = 3'd2,
      S_WASH  = 3'd3,
      S_DRAIN = 3'd4,
      S_SPIN  = 3'd5,
      S_DONE  = 3'd6
   } st_t;

   st_t           st_q, st_d;
   logic          paused_q, paused_d;
   logic [RW-1:0] rem_q, rem_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [2:0]    kv_q;
   logic          evt, busy, timed, act;

`ifdef WASH_DIR_ALT_EN
   logic [RW-1:0] dir_cnt_q, dir_cnt_d;
   logic          rev_q, rev_d;
`endif

   assign evt   = (key_value != kv_q);
   assign busy  = (st_q == S_FILL) || (st_q == S_WASH) || (st_q == S_DRAIN) || (st_q == S_SPIN);
   assign timed = busy || (st_q == S_DONE);

   // Next-state: an acting command pre-empts the tick of the same cycle
   always_comb begin
      st_d     = st_q;
      paused_d = paused_q;
      rem_d    = rem_q;
      pre_d    = pre_q;
      act      = 1'b0;
`ifdef WASH_DIR_ALT_EN
      dir_cnt_d = dir_cnt_q;
      rev_d     = rev_q;
`endif
      if (evt) begin
         case (key_value)
            3'd1: begin
               if (st_q == S_IDLE) begin
                  st_d = S_READY;
                  act  = 1'b1;
               end else if (st_q != S_READY) begin
                  st_d     = S_READY;
                  paused_d = 1'b0;
                  rem_d    = '0;
                  pre_d    = '0;
                  act      = 1'b1;
               end
            end
            3'd2: begin
               if (st_q == S_READY) begin
                  st_d     = S_FILL;
                  paused_d = 1'b0;
                  rem_d    = RW'(FILL_S);
                  pre_d    = '0;
                  act      = 1'b1;
               end
            end
            3'd3: begin
               if (st_q == S_FILL) begin
                  st_d  = S_WASH;
                  rem_d = RW'(WASH_S);
                  pre_d = '0;
                  act   = 1'b1;
`ifdef WASH_DIR_ALT_EN
                  dir_cnt_d = '0;
                  rev_d     = 1'b0;
`endif
               end
            end
            3'd4: begin
               if (busy && !paused_q) begin
                  paused_d = 1'b1;
                  act      = 1'b1;
               end
            end
            3'd5: begin
               if (busy && paused_q) begin
                  paused_d = 1'b0;
                  act      = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (!act && timed && !paused_q) begin
         if (pre_q == PW'(TICK_DIV - 1)) begin
            pre_d = '0;
            if (rem_q == RW'(1)) begin
               case (st_q)
                  S_FILL: begin
                     st_d  = S_WASH;
                     rem_d = RW'(WASH_S);
`ifdef WASH_DIR_ALT_EN
                     dir_cnt_d = '0;
                     rev_d     = 1'b0;
`endif
                  end
                  S_WASH:  begin st_d = S_DRAIN; rem_d = RW'(DRAIN_S); end
                  S_DRAIN: begin st_d = S_SPIN;  rem_d = RW'(SPIN_S);  end
                  S_SPIN:  begin st_d = S_DONE;  rem_d = RW'(DONE_S);  end
                  S_DONE:  begin st_d = S_IDLE;  rem_d = '0;           end
                  default: ;
               endcase
            end else begin
               rem_d = rem_q - RW'(1);
`ifdef WASH_DIR_ALT_EN
               if (st_q == S_WASH) begin
                  if (dir_cnt_q == RW'(DIR_S - 1)) begin
                     dir_cnt_d = '0;
                     rev_d     = ~rev_q;
                  end else begin
                     dir_cnt_d = dir_cnt_q + RW'(1);
                  end
               end
`endif
            end
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   // State, timers and actuator outputs decoded from the next state
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         kv_q      <= '0;
         st_q      <= S_IDLE;
         paused_q  <= 1'b0;
         rem_q     <= '0;
         pre_q     <= '0;
         valve_in  <= 1'b0;
         valve_out <= 1'b0;
         motor_fwd <= 1'b0;
         spin      <= 1'b0;
         buzzer    <= 1'b0;
`ifdef WASH_DIR_ALT_EN
         dir_cnt_q <= '0;
         rev_q     <= 1'b0;
         motor_rev <= 1'b0;
`endif
      end else begin
         kv_q      <= key_value;
         st_q      <= st_d;
         paused_q  <= paused_d;
         rem_q     <= rem_d;
         pre_q     <= pre_d;
         valve_in  <= (st_d == S_FILL) && !paused_d;
         valve_out <= ((st_d == S_DRAIN) || (st_d == S_SPIN)) && !paused_d;
         spin      <= (st_d == S_SPIN) && !paused_d;
         buzzer    <= (st_d == S_DONE) && !paused_d;
`ifdef WASH_DIR_ALT_EN
         dir_cnt_q <= dir_cnt_d;
         rev_q     <= rev_d;
         motor_fwd <= (st_d == S_WASH) && !paused_d && !rev_d;
         motor_rev <= (st_d == S_WASH) && !paused_d && rev_d;
`else
         motor_fwd <= (st_d == S_WASH) && !paused_d;
`endif
      end
   end

`ifndef WASH_DIR_ALT_EN
   assign motor_rev = 1'b0;
`endif

   assign state    = st_q;
   assign paused   = paused_q;
   assign remain_s = rem_q;

endmodule

// File: tb/tb_wash_ctrl.sv
// Directed bench for wash_ctrl with a 4-cycle tick and short state durations.
module tb_wash_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] key;
   logic       valve_in, valve_out, motor_fwd, motor_rev, spin, buzzer, paused;
   logic [2:0] state;
   logic [9:0] remain_s;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   wash_ctrl #(
      .TICK_DIV(4), .FILL_S(3), .WASH_S(4), .DRAIN_S(2), .SPIN_S(2), .DONE_S(1), .DIR_S(1)
   ) dut (
      .CLK(clk), .RST_N(rst_n), .key_value(key),
      .valve_in(valve_in), .valve_out(valve_out), .motor_fwd(motor_fwd), .motor_rev(motor_rev),
      .spin(spin), .buzzer(buzzer), .paused(paused), .state(state), .remain_s(remain_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [5:0] outs();
      return {valve_in, valve_out, motor_fwd, motor_rev, spin, buzzer};
   endfunction

   // Count cycles spent in state s (bounded), then check the successor state
   task automatic measure(input string tag, input int s, input int len, input logic [5:0] o,
                          input int nxt);
      int n  = 0;
      int bz = 0;
      check({tag, "_outs"}, 32'(outs()), 32'(o));
      while (32'(state) == s && n < 200) begin
         if (buzzer) bz++;
         step(1);
         n++;
      end
      check({tag, "_len"}, n, len);
      check({tag, "_next"}, 32'(state), nxt);
      check({tag, "_buzz"}, bz, (s == 6) ? len : 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      logic efwd, erev;
      rst_n = 1'b0;
      key   = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(state), 0);
      check("rst_outs", 32'({outs(), paused}), 0);
      check("rst_remain", 32'(remain_s), 0);
      rst_n = 1'b1;
      step(1);
      check("idle_state", 32'(state), 0);

      // full cycle
      key = 3'd1; step(1);
      check("ready_state", 32'(state), 1);
      check("ready_remain", 32'(remain_s), 0);
      key = 3'd2; step(1);
      check("fill_state", 32'(state), 2);
      check("fill_remain", 32'(remain_s), 3);
      measure("fill", 2, 12, 6'b100000, 3);
      measure("wash", 3, 16, 6'b001000, 4);
      measure("drain", 4, 8, 6'b010000, 5);
      measure("spin", 5, 8, 6'b010010, 6);
      measure("done", 6, 4, 6'b000001, 0);
      check("end_outs", 32'(outs()), 0);
      check("end_remain", 32'(remain_s), 0);

      // early fill end
      key = 3'd1; step(1);
      key = 3'd2; step(1);
      check("ef_remain3", 32'(remain_s), 3);
      key = 3'd3; step(1);
      check("ef_state", 32'(state), 3);
      check("ef_remain", 32'(remain_s), 4);
      check("ef_valve_in", 32'(valve_in), 0);
      check("ef_motor_fwd", 32'(motor_fwd), 1);

      // pause with two prescaler counts already spent in the last-but-one second
      step(8);
      check("pr_remain2", 32'(remain_s), 2);
      step(2);
      key = 3'd4; step(1);
      check("pr_paused", 32'(paused), 1);
      check("pr_outs", 32'(outs()), 0);
      check("pr_remain", 32'(remain_s), 2);
      step(20);
      check("pr_hold_remain", 32'(remain_s), 2);
      check("pr_hold_state", 32'(state), 3);
      check("pr_hold_outs", 32'(outs()), 0);
      key = 3'd5; step(1);
      check("rs_paused", 32'(paused), 0);
      check("rs_motor_fwd", 32'(motor_fwd), 1);
      check("rs_remain", 32'(remain_s), 2);
      n = 0;
      while (state == 3'd3 && n < 200) begin step(1); n++; end
      check("rs_exit_len", n, 6);
      check("rs_exit_state", 32'(state), 4);

      // abort in SPIN
      n = 0;
      while (state != 3'd5 && n < 200) begin step(1); n++; end
      check("ab_in_spin", 32'(state), 5);
      key = 3'd1; step(1);
      check("ab_state", 32'(state), 1);
      check("ab_outs", 32'({outs(), paused}), 0);
      check("ab_remain", 32'(remain_s), 0);
      step(5);
      check("ab_hold_state", 32'(state), 1);

      // abort while paused clears pause
      key = 3'd2; step(1);
      key = 3'd4; step(1);
      check("abp_paused", 32'(paused), 1);
      key = 3'd1; step(1);
      check("abp_state", 32'(state), 1);
      check("abp_unpaused", 32'(paused), 0);

      // wash direction
      key = 3'd2; step(1);
      key = 3'd3; step(1);
      for (int i = 0; i < 16; i++) begin
`ifdef WASH_DIR_ALT_EN
         efwd = ((i / 4) % 2 == 0);
         erev = !efwd;
`else
         efwd = 1'b1;
         erev = 1'b0;
`endif
         check("dir_fwd", 32'(motor_fwd), 32'(efwd));
         check("dir_rev", 32'(motor_rev), 32'(erev));
         step(1);
      end
      check("dir_exit", 32'(state), 4);

      // asynchronous reset in FILL
      key = 3'd1; step(1);
      key = 3'd2; step(1);
      step(2);
      check("rf_valve_in_pre", 32'(valve_in), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rf_valve_in", 32'(valve_in), 0);
      check("rf_state", 32'(state), 0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      step(3);
      check("rf_idle_hold", 32'(state), 0);
      key = 3'd1; step(1);
      check("rf_ready", 32'(state), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
